bram_dual_pipe: RTL and testbench
=================================

BRAM_DUAL_PIPE -- requirements
Module: bram_dual_pipe

Interface
REQ-001 Parameter memSize_p, default 8: address width; depth is 2**memSize_p words.
REQ-002 Parameter dataWidth_p, default 32: word width in bits.
REQ-003 Parameter laneWidth_p, default 8: byte-lane width; dataWidth_p SHALL be an integer multiple of it; lane count NL = dataWidth_p/laneWidth_p.
REQ-004 Parameter readLatency_p, default 1: read latency in clocks, legal values 1 or 2.
REQ-005 Parameter writeFirst_p, default 1: 1 = same-address same-cycle read returns new data; 0 = returns old data.
REQ-006 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_ni  input  1  asynchronous, active-low reset.
REQ-008 write_i  input  1  write request, sampled at rising edge.
REQ-009 wstrb_i  input  NL  per-lane write enable; bit k covers data bits [k*laneWidth_p +: laneWidth_p].
REQ-010 waddr_i  input  memSize_p  write address.
REQ-011 data_i  input  dataWidth_p  write data.
REQ-012 read_i  input  1  read request, sampled at rising edge.
REQ-013 raddr_i  input  memSize_p  read address.
REQ-014 data_o  output  dataWidth_p  registered read data.
REQ-015 valid_o  output  1  high for exactly one cycle when data_o carries a newly completed read.

Function
REQ-016 On a rising edge with write_i=1, the block SHALL update only the lanes of memory[waddr_i] whose wstrb_i bit is 1; other lanes keep their contents.
REQ-017 write_i=1 with wstrb_i=0 SHALL leave memory unchanged.
REQ-018 On a rising edge with read_i=1, the block SHALL capture read word R for raddr_i into stage 1 and set the stage-1 valid flag; with read_i=0, the stage-1 valid flag SHALL clear and stage-1 data SHALL hold.
REQ-019 Collision (write_i=1, read_i=1, waddr_i==raddr_i, same edge) with writeFirst_p=1: R SHALL take strobed lanes from data_i and unstrobed lanes from the prior memory contents.
REQ-020 Collision with writeFirst_p=0: R SHALL equal the memory contents before that edge's write.
REQ-021 readLatency_p=1: data_o and valid_o SHALL be the stage-1 registers, so data is valid one edge after the request.
REQ-022 readLatency_p=2: a second register stage SHALL copy stage-1 data and valid on every edge, so data is valid two edges after the request.
REQ-023 In both latencies, the output data register SHALL load only when its incoming valid flag is 1, and SHALL otherwise hold its last value.
REQ-024 Back-to-back reads SHALL be accepted every cycle (throughput 1/clock), with no stall and no back-pressure.
REQ-025 Data captured in a read stage SHALL NOT be modified by later writes to the same address.
REQ-026 Read and write addresses are independent; writes and reads to different addresses in the same cycle SHALL both complete.
REQ-027 Out-of-range parameter values (readLatency_p not 1 or 2, or dataWidth_p not a multiple of laneWidth_p) SHALL stop elaboration with an error.

Reset
REQ-028 While rst_ni=0, data_o, valid_o and all pipeline data and valid registers SHALL be 0, asynchronously.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 An in-flight read at reset assertion SHALL be discarded, with no valid_o pulse after release.
REQ-031 Writes and reads SHALL be ignored while rst_ni=0.
REQ-032 The first request SHALL be accepted on the first rising edge after rst_ni deasserts.

Verification
REQ-033 Lane write (defaults, readLatency_p=1): write addr 5 = 0xAABBCCDD with wstrb 1111, then write addr 5 = 0x11223344 with wstrb 0101, then read addr 5 -> one cycle later data_o=0xAA22CC44 and valid_o pulses for 1 cycle.
REQ-034 Collision, writeFirst_p=1: addr 3 holds 0x00000000; same edge write 0xDEADBEEF with wstrb 0011 and read addr 3 -> data_o=0x0000BEEF; with writeFirst_p=0 -> data_o=0x00000000.
REQ-035 Latency 2 streaming: reads of addrs 0,1,2 on consecutive edges -> valid_o high for edges 2,3,4 after the first request, with data in order; data_o holds the addr-2 value afterwards.
REQ-036 Capture isolation (readLatency_p=2): read addr 7 (=0x1), then write addr 7=0x2 on the next edge -> data_o=0x1.
REQ-037 Reset mid-read: assert rst_ni=0 one cycle after a read request, release 3 cycles later -> data_o=0 and valid_o stays 0; a subsequent read of an address written before reset returns its pre-reset value.
REQ-038 Randomised dual-port traffic against a byte-lane reference model, for all four readLatency_p/writeFirst_p combinations -> every valid_o beat matches the model.

Source files
------------

// File: rtl/bram_dual_pipe.sv
// bram_dual_pipe: simple dual-port RAM with byte-lane write strobes and a
// registered read pipeline of one or two stages. Memory contents survive
// reset; only the read pipeline is cleared.
module bram_dual_pipe #(
  parameter int memSize_p     = 8,
  parameter int dataWidth_p   = 32,
  parameter int laneWidth_p   = 8,
  parameter int readLatency_p = 1,
  parameter int writeFirst_p  = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 write_i,
  input  logic [dataWidth_p/laneWidth_p-1:0]   wstrb_i,
  input  logic [memSize_p-1:0]                 waddr_i,
  input  logic [dataWidth_p-1:0]               data_i,
  input  logic                                 read_i,
  input  logic [memSize_p-1:0]                 raddr_i,
  output logic [dataWidth_p-1:0]               data_o,
  output logic                                 valid_o
);

  localparam int NL    = dataWidth_p / laneWidth_p;
  localparam int DEPTH = 32'sd1 << memSize_p;

  // Reject parameter sets the pipeline and lane logic cannot represent.
  generate
    if ((readLatency_p != 32'sd1) && (readLatency_p != 32'sd2)) begin : g_bad_latency
      $error("bram_dual_pipe: readLatency_p must be 1 or 2");
    end
    if ((dataWidth_p % laneWidth_p) != 32'sd0) begin : g_bad_lanes
      $error("bram_dual_pipe: dataWidth_p must be a multiple of laneWidth_p");
    end
  endgenerate

  // Combine a stored word with incoming data, taking strobed lanes from new_w.
  function automatic logic [dataWidth_p-1:0] merge_lanes(
    input logic [dataWidth_p-1:0] old_w,
    input logic [dataWidth_p-1:0] new_w,
    input logic [NL-1:0]          strb
  );
    logic [dataWidth_p-1:0] res;
    res = old_w;
    for (int k = 0; k < NL; k++) begin
      if (strb[k]) begin
        res[k*laneWidth_p +: laneWidth_p] = new_w[k*laneWidth_p +: laneWidth_p];
      end else begin
        res[k*laneWidth_p +: laneWidth_p] = old_w[k*laneWidth_p +: laneWidth_p];
      end
    end
    return res;
  endfunction

  logic [dataWidth_p-1:0] mem_r [DEPTH];
  logic [dataWidth_p-1:0] mem_word_s;
  logic [dataWidth_p-1:0] rd_word_s;
  logic                   collide_s;
  logic [dataWidth_p-1:0] s1_data_r;
  logic                   s1_valid_r;

  // Lane-enabled memory write; no reset so contents persist, blocked while in reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && write_i) begin
      for (int k = 0; k < NL; k++) begin
        if (wstrb_i[k]) begin
          mem_r[waddr_i][k*laneWidth_p +: laneWidth_p] <= data_i[k*laneWidth_p +: laneWidth_p];
        end
      end
    end
  end

  // Read word selection, forwarding strobed write lanes on a same-address collision.
  always_comb begin
    mem_word_s = mem_r[raddr_i];
    collide_s  = write_i && (waddr_i == raddr_i);
    if ((writeFirst_p != 32'sd0) && collide_s) begin
      rd_word_s = merge_lanes(mem_word_s, data_i, wstrb_i);
    end else begin
      rd_word_s = mem_word_s;
    end
  end

  // Stage 1: capture the read word on request; data holds when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {dataWidth_p{1'b0}};
    end else begin
      s1_valid_r <= read_i;
      if (read_i) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (readLatency_p == 32'sd2) begin : g_lat2
      logic [dataWidth_p-1:0] s2_data_r;
      logic                   s2_valid_r;

      // Stage 2: follow stage-1 valid every edge, load data only on a valid beat.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          s2_valid_r <= 1'b0;
          s2_data_r  <= {dataWidth_p{1'b0}};
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign data_o  = s2_data_r;
      assign valid_o = s2_valid_r;
    end else begin : g_lat1
      assign data_o  = s1_data_r;
      assign valid_o = s1_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dual_pipe.sv
// Testbench for bram_dual_pipe: four instances cover every readLatency_p /
// writeFirst_p pairing and share one stimulus stream. A word-array reference
// model predicts each read result and when it should appear on the output.
module tb_bram_dual_pipe;

  logic        clk;
  logic        rst_n;
  logic        write_s;
  logic [3:0]  wstrb_s;
  logic [7:0]  waddr_s;
  logic [31:0] wdata_s;
  logic        read_s;
  logic [7:0]  raddr_s;
  logic [31:0] dout [4];
  logic        vout [4];

  int checks = 0;
  int fails  = 0;
  int n      = 0;

  // Reference model state
  logic [31:0] mem_m [256];
  bit          rv    [8192];
  logic [31:0] rd_wf1[8192];
  logic [31:0] rd_wf0[8192];
  logic [31:0] last_exp[4];

  typedef struct {
    logic        w;
    logic [3:0]  strb;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        r;
    logic [7:0]  ra;
    logic        ev;
    logic [31:0] ed_wf1;
    logic [31:0] ed_wf0;
  } vec_t;
  vec_t tbl[11];

  bram_dual_pipe #(.readLatency_p(1), .writeFirst_p(1)) u_l1_wf1 (
    .clk_i(clk), .rst_ni(rst_n), .write_i(write_s), .wstrb_i(wstrb_s), .waddr_i(waddr_s),
    .data_i(wdata_s), .read_i(read_s), .raddr_i(raddr_s), .data_o(dout[0]), .valid_o(vout[0]));
  bram_dual_pipe #(.readLatency_p(1), .writeFirst_p(0)) u_l1_wf0 (
    .clk_i(clk), .rst_ni(rst_n), .write_i(write_s), .wstrb_i(wstrb_s), .waddr_i(waddr_s),
    .data_i(wdata_s), .read_i(read_s), .raddr_i(raddr_s), .data_o(dout[1]), .valid_o(vout[1]));
  bram_dual_pipe #(.readLatency_p(2), .writeFirst_p(1)) u_l2_wf1 (
    .clk_i(clk), .rst_ni(rst_n), .write_i(write_s), .wstrb_i(wstrb_s), .waddr_i(waddr_s),
    .data_i(wdata_s), .read_i(read_s), .raddr_i(raddr_s), .data_o(dout[2]), .valid_o(vout[2]));
  bram_dual_pipe #(.readLatency_p(2), .writeFirst_p(0)) u_l2_wf0 (
    .clk_i(clk), .rst_ni(rst_n), .write_i(write_s), .wstrb_i(wstrb_s), .waddr_i(waddr_s),
    .data_i(wdata_s), .read_i(read_s), .raddr_i(raddr_s), .data_o(dout[3]), .valid_o(vout[3]));

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k < 2) ? 1 : 2;
  endfunction

  task automatic drive(input logic w, input logic [3:0] strb, input logic [7:0] wa,
                       input logic [31:0] wd, input logic r, input logic [7:0] ra);
    write_s = w; wstrb_s = strb; waddr_s = wa; wdata_s = wd; read_s = r; raddr_s = ra;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b0, 8'd0);
  endtask

  // One clock: update the model at the rising edge, compare all instances at the falling edge.
  task automatic cycle();
    logic [31:0] old_w;
    logic [31:0] new_w;
    int idx;
    @(posedge clk);
    n++;
    if (rst_n) begin
      old_w = mem_m[raddr_s];
      new_w = mem_m[waddr_s];
      for (int b = 0; b < 4; b++) begin
        if (wstrb_s[b]) new_w[8*b +: 8] = wdata_s[8*b +: 8];
      end
      rv[n]     = read_s;
      rd_wf0[n] = old_w;
      rd_wf1[n] = (write_s && (waddr_s == raddr_s)) ? new_w : old_w;
      if (write_s) mem_m[waddr_s] = new_w;
    end else begin
      rv[n] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      idx = n - lat_of(k) + 1;
      if (rv[idx]) last_exp[k] = (k % 2 == 0) ? rd_wf1[idx] : rd_wf0[idx];
      chk($sformatf("model dut%0d valid_o cyc%0d", k, n), {31'b0, vout[k]}, {31'b0, rv[idx]});
      chk($sformatf("model dut%0d data_o cyc%0d", k, n), dout[k], last_exp[k]);
    end
  endtask

  // Assert reset away from the clock edge, check the asynchronous clear, hold for ncyc edges.
  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("async reset dut%0d valid_o", k), {31'b0, vout[k]}, 32'h0);
      chk($sformatf("async reset dut%0d data_o", k), dout[k], 32'h0);
      last_exp[k] = 32'h0;
    end
    for (int i = 0; i <= n; i++) rv[i] = 1'b0;
    repeat (ncyc) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 4; k++) last_exp[k] = 32'h0;
    #1;
    do_reset(2);

    // Give every word a known value
    for (int a = 0; a < 256; a++) begin
      drive(1'b1, 4'hF, a[7:0], 32'h0, 1'b0, 8'd0);
      cycle();
    end

    // Directed table for the latency-1 instances
    tbl[0]  = '{1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b0, 8'd0, 1'b0, 32'h00000000, 32'h00000000};
    tbl[1]  = '{1'b1, 4'h5, 8'd5, 32'h11223344, 1'b0, 8'd0, 1'b0, 32'h00000000, 32'h00000000};
    tbl[2]  = '{1'b0, 4'h0, 8'd0, 32'h00000000, 1'b1, 8'd5, 1'b1, 32'hAA22CC44, 32'hAA22CC44};
    tbl[3]  = '{1'b0, 4'h0, 8'd0, 32'h00000000, 1'b0, 8'd0, 1'b0, 32'hAA22CC44, 32'hAA22CC44};
    tbl[4]  = '{1'b1, 4'h3, 8'd3, 32'hDEADBEEF, 1'b1, 8'd3, 1'b1, 32'h0000BEEF, 32'h00000000};
    tbl[5]  = '{1'b0, 4'h0, 8'd0, 32'h00000000, 1'b0, 8'd0, 1'b0, 32'h0000BEEF, 32'h00000000};
    tbl[6]  = '{1'b1, 4'hF, 8'd7, 32'h00000001, 1'b0, 8'd0, 1'b0, 32'h0000BEEF, 32'h00000000};
    tbl[7]  = '{1'b1, 4'h8, 8'd4, 32'hCAFEF00D, 1'b1, 8'd7, 1'b1, 32'h00000001, 32'h00000001};
    tbl[8]  = '{1'b0, 4'h0, 8'd0, 32'h00000000, 1'b1, 8'd4, 1'b1, 32'hCA000000, 32'hCA000000};
    tbl[9]  = '{1'b1, 4'h0, 8'd4, 32'h12345678, 1'b1, 8'd4, 1'b1, 32'hCA000000, 32'hCA000000};
    tbl[10] = '{1'b0, 4'h0, 8'd0, 32'h00000000, 1'b0, 8'd0, 1'b0, 32'hCA000000, 32'hCA000000};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].w, tbl[i].strb, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra);
      cycle();
      chk($sformatf("tbl%0d wf1 valid_o", i), {31'b0, vout[0]}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d wf1 data_o", i), dout[0], tbl[i].ed_wf1);
      chk($sformatf("tbl%0d wf0 valid_o", i), {31'b0, vout[1]}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d wf0 data_o", i), dout[1], tbl[i].ed_wf0);
    end

    // Latency-2 streaming of three back-to-back reads
    for (int a = 0; a < 3; a++) begin
      drive(1'b1, 4'hF, a[7:0], 32'h100 + a, 1'b0, 8'd0);
      cycle();
    end
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd0); cycle();
    chk("stream edge1 valid_o", {31'b0, vout[2]}, 32'h0);
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd1); cycle();
    chk("stream edge2 valid_o", {31'b0, vout[2]}, 32'h1);
    chk("stream edge2 data_o", dout[2], 32'h100);
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd2); cycle();
    chk("stream edge3 valid_o", {31'b0, vout[2]}, 32'h1);
    chk("stream edge3 data_o", dout[2], 32'h101);
    idle(); cycle();
    chk("stream edge4 valid_o", {31'b0, vout[2]}, 32'h1);
    chk("stream edge4 data_o", dout[2], 32'h102);
    cycle();
    chk("stream hold valid_o", {31'b0, vout[2]}, 32'h0);
    chk("stream hold data_o", dout[2], 32'h102);

    // Captured data is isolated from a following write to the same address
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd7); cycle();
    drive(1'b1, 4'hF, 8'd7, 32'h2, 1'b0, 8'd0); cycle();
    chk("isolation valid_o", {31'b0, vout[2]}, 32'h1);
    chk("isolation data_o", dout[2], 32'h1);
    idle(); cycle();
    chk("isolation hold data_o", dout[2], 32'h1);

    // Reset with a read in flight; writes during reset are ignored
    drive(1'b1, 4'hF, 8'd9, 32'h99, 1'b0, 8'd0); cycle();
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd9); cycle();
    drive(1'b1, 4'hF, 8'd9, 32'h55, 1'b1, 8'd9);
    do_reset(3);
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("post-reset%0d lat2 valid_o", i), {31'b0, vout[2]}, 32'h0);
      chk($sformatf("post-reset%0d lat2 data_o", i), dout[2], 32'h0);
    end
    drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd9); cycle();
    chk("post-reset read lat1 data_o", dout[0], 32'h99);
    idle(); cycle();
    chk("post-reset read lat2 data_o", dout[2], 32'h99);

    // Randomised traffic on a small address window to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            32'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
      if (i == 1000) do_reset(2);
      else cycle();
    end
    idle();
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
